// File: rtl/iddrx8_word_align.sv
// iddrx8_word_align
// Word-alignment controller for an IDDRX8-style 1:8 DDR gearbox (16-bit Q).
// The gearbox is slipped one bit at a time with ALIGNWD until the deserialized
// word equals the training PATTERN for MATCH_CNT consecutive SCLK cycles.
// After each slip (and after every START) the controller waits SETTLE_CYC
// cycles so the gearbox output has time to settle before Q is judged.
// If all 16 alignments are tried without a lock, ERROR is raised and held.
//
// Optional build macro: IDDRX8_ALIGN_MONITOR_EN
//   defined   : while locked, Q is still compared every cycle. Four
//               consecutive mismatches drop LOCKED and restart alignment.
//   undefined : LOCKED is held regardless of Q until START or reset.
//
// Handshake: ALIGNWD is a single-cycle registered request with no
// acknowledge. The gearbox is assumed to act on every cycle it sees
// ALIGNWD=1. Two requests are always separated by at least SETTLE_CYC+1
// low cycles.
//
// DBG_STATE exposes the FSM state encoding for checkers:
//   0 IDLE, 1 SETTLE, 2 CHECK, 3 PULSE, 4 LOCK, 5 FAIL.

module iddrx8_word_align #(
  parameter logic [15:0] PATTERN    = 16'h00FF,
  parameter int          SETTLE_CYC = 4,
  parameter int          MATCH_CNT  = 4
) (
  input  logic        SCLK,
  input  logic        RSTN,
  input  logic        START,
  input  logic [15:0] Q,
  output logic        ALIGNWD,
  output logic        LOCKED,
  output logic        ERROR,
  output logic [3:0]  SLIP_CNT,
  output logic [2:0]  DBG_STATE
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_CHECK  = 3'd2,
    S_PULSE  = 3'd3,
    S_LOCK   = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  // Terminal counts for the 3-bit settle and match counters.
  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYC - 1);
  localparam logic [2:0] MATCH_LAST  = 3'(MATCH_CNT - 1);
  localparam logic [3:0] SLIP_MAX    = 4'd15;

  state_t     state_q,      state_d;
  logic [2:0] settle_cnt_q, settle_cnt_d;
  logic [2:0] match_cnt_q,  match_cnt_d;
  logic       alignwd_q,    alignwd_d;
  logic       locked_q,     locked_d;
  logic       error_q,      error_d;
  logic [3:0] slip_cnt_q,   slip_cnt_d;

`ifdef IDDRX8_ALIGN_MONITOR_EN
  // Consecutive mismatches seen while locked; the fourth one breaks the lock.
  localparam logic [1:0] MISS_LAST = 2'd3;
  logic [1:0] miss_cnt_q, miss_cnt_d;
`endif

  logic q_match;

  // Training word comparison used by CHECK (and LOCK when monitoring).
  always_comb begin
    q_match = (Q == PATTERN);
  end

  // Next-state and next-output logic; START overrides every transition.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    match_cnt_d  = match_cnt_q;
    alignwd_d    = 1'b0;
    locked_d     = locked_q;
    error_d      = error_q;
    slip_cnt_d   = slip_cnt_q;
`ifdef IDDRX8_ALIGN_MONITOR_EN
    miss_cnt_d   = miss_cnt_q;
`endif

    if (START) begin
      // Restart wins over lock/fail/pulse completion on the same edge.
      state_d      = S_SETTLE;
      settle_cnt_d = 3'd0;
      match_cnt_d  = 3'd0;
      locked_d     = 1'b0;
      error_d      = 1'b0;
      slip_cnt_d   = 4'd0;
`ifdef IDDRX8_ALIGN_MONITOR_EN
      miss_cnt_d   = 2'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end

        S_SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_d      = S_CHECK;
            settle_cnt_d = 3'd0;
            match_cnt_d  = 3'd0;
          end else begin
            settle_cnt_d = settle_cnt_q + 3'd1;
          end
        end

        S_CHECK: begin
          if (q_match) begin
            if (match_cnt_q == MATCH_LAST) begin
              state_d     = S_LOCK;
              locked_d    = 1'b1;
              match_cnt_d = 3'd0;
`ifdef IDDRX8_ALIGN_MONITOR_EN
              miss_cnt_d  = 2'd0;
`endif
            end else begin
              match_cnt_d = match_cnt_q + 3'd1;
            end
          end else if (slip_cnt_q != SLIP_MAX) begin
            // Request one bit slip; ALIGNWD is high for the PULSE cycle only.
            state_d     = S_PULSE;
            alignwd_d   = 1'b1;
            match_cnt_d = 3'd0;
          end else begin
            // Every rotation has been tried: give up without slipping again.
            state_d     = S_FAIL;
            error_d     = 1'b1;
            match_cnt_d = 3'd0;
          end
        end

        S_PULSE: begin
          // SLIP_CNT < 15 is guaranteed here, so the increment cannot wrap.
          state_d      = S_SETTLE;
          settle_cnt_d = 3'd0;
          slip_cnt_d   = slip_cnt_q + 4'd1;
        end

        S_LOCK: begin
`ifdef IDDRX8_ALIGN_MONITOR_EN
          if (q_match) begin
            miss_cnt_d = 2'd0;
          end else if (miss_cnt_q == MISS_LAST) begin
            // Lock lost: realign from scratch.
            state_d      = S_SETTLE;
            settle_cnt_d = 3'd0;
            locked_d     = 1'b0;
            slip_cnt_d   = 4'd0;
            miss_cnt_d   = 2'd0;
          end else begin
            miss_cnt_d = miss_cnt_q + 2'd1;
          end
`else
          state_d = S_LOCK;
`endif
        end

        S_FAIL: begin
          state_d = S_FAIL;
        end

        default: begin
          state_d      = S_IDLE;
          settle_cnt_d = 3'd0;
          match_cnt_d  = 3'd0;
          locked_d     = 1'b0;
          error_d      = 1'b0;
          slip_cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // State and registered outputs; reset clears everything asynchronously,
  // which also truncates an in-flight ALIGNWD pulse.
  always_ff @(posedge SCLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q      <= S_IDLE;
      settle_cnt_q <= 3'd0;
      match_cnt_q  <= 3'd0;
      alignwd_q    <= 1'b0;
      locked_q     <= 1'b0;
      error_q      <= 1'b0;
      slip_cnt_q   <= 4'd0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      match_cnt_q  <= match_cnt_d;
      alignwd_q    <= alignwd_d;
      locked_q     <= locked_d;
      error_q      <= error_d;
      slip_cnt_q   <= slip_cnt_d;
    end
  end

`ifdef IDDRX8_ALIGN_MONITOR_EN
  // Miss counter for lock monitoring.
  always_ff @(posedge SCLK or negedge RSTN) begin
    if (!RSTN) begin
      miss_cnt_q <= 2'd0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
    end
  end
`endif

  // Output mapping.
  always_comb begin
    ALIGNWD   = alignwd_q;
    LOCKED    = locked_q;
    ERROR     = error_q;
    SLIP_CNT  = slip_cnt_q;
    DBG_STATE = state_q;
  end

endmodule

// File: tb/tb_iddrx8_word_align.sv
// tb_iddrx8_word_align
// Bench for iddrx8_word_align with default parameters. A gearbox model
// presents PATTERN rotated by a slip offset; each ALIGNWD cycle moves the
// offset one step towards alignment. A fixed-word mode holds Q constant.
// Build with +define+IDDRX8_ALIGN_MONITOR_EN to exercise lock monitoring.
`timescale 1ns/1ps

module tb_iddrx8_word_align;

  localparam logic [15:0] PAT    = 16'h00FF;
  localparam int          SETTLE = 4;
  localparam int          W      = 11;   // {locked, error, slip[3:0], pulses[4:0]}
  localparam logic [2:0]  ST_IDLE   = 3'd0;
  localparam logic [2:0]  ST_SETTLE = 3'd1;
  localparam logic [2:0]  ST_CHECK  = 3'd2;
  localparam logic [2:0]  ST_LOCK   = 3'd4;
  localparam logic [2:0]  ST_FAIL   = 3'd5;
  localparam int          BUDGET = 400;

  // ---------------- clock / reset ----------------
  logic        sclk  = 1'b0;
  logic        rstn  = 1'b1;
  logic        start = 1'b0;
  logic [15:0] q_in;
  logic        alignwd, locked, error;
  logic [3:0]  slip;
  logic [2:0]  dbg_state;

  always #5 sclk = ~sclk;

  iddrx8_word_align dut (
    .SCLK      (sclk),
    .RSTN      (rstn),
    .START     (start),
    .Q         (q_in),
    .ALIGNWD   (alignwd),
    .LOCKED    (locked),
    .ERROR     (error),
    .SLIP_CNT  (slip),
    .DBG_STATE (dbg_state)
  );

  // ---------------- gearbox model ----------------
  logic [3:0]  off        = 4'd0;
  bit          fixed_mode = 1'b0;
  logic [15:0] fixed_word = 16'h0000;
  int          pulses     = 0;
  int          cyc        = 0;
  int          last_pulse = -100;
  int          errors     = 0;
  int          checks     = 0;

  function automatic logic [15:0] rotl(input logic [15:0] w, input logic [3:0] n);
    logic [15:0] r;
    r = w;
    for (int i = 0; i < int'(n); i++) r = {r[14:0], r[15]};
    return r;
  endfunction

  always_comb q_in = fixed_mode ? fixed_word : rotl(PAT, off);

  // Sampled away from the active edge: count slips, rotate Q, check spacing.
  always @(negedge sclk) begin
    cyc++;
    if (alignwd === 1'b1) begin
      if (last_pulse >= 0) begin
        checks++;
        if ((cyc - last_pulse) < SETTLE + 2) begin
          errors++;
          $display("FAIL alignwd_gap: got %0d cycles, required >= %0d", cyc - last_pulse, SETTLE + 2);
        end
      end
      last_pulse = cyc;
      pulses++;
      if (!fixed_mode) off = off - 4'd1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input bit l, input bit e, input int s, input int p);
    return {l, e, 4'(s), 5'(p)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge sclk);
    rstn  = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge sclk);
    rstn  = 1'b1;
    @(negedge sclk);
  endtask

  task automatic set_model(input logic [3:0] o, input bit fx, input logic [15:0] wd);
    off        = o;
    fixed_mode = fx;
    fixed_word = wd;
    pulses     = 0;
    last_pulse = -100;
  endtask

  // Called at a negedge: START is sampled on exactly the next rising edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge sclk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!(locked === 1'b1 || error === 1'b1) && n < BUDGET) begin
      @(negedge sclk);
      n++;
    end
    check(name, {31'd0, (locked === 1'b1 || error === 1'b1)}, 32'd1);
  endtask

  task automatic wait_alignwd(input string name);
    int n;
    n = 0;
    while (alignwd !== 1'b1 && n < BUDGET) begin
      @(negedge sclk);
      n++;
    end
    check(name, {31'd0, alignwd}, 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]   off;
    bit           fixed;
    logic [15:0]  word;
    logic [W-1:0] exp;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] exp_w, got_w;
    int           seen;

    vecs[0] = '{4'd0,  1'b0, 16'h0000, mk(1, 0, 0, 0)};
    vecs[1] = '{4'd3,  1'b0, 16'h0000, mk(1, 0, 3, 3)};
    vecs[2] = '{4'd1,  1'b0, 16'h0000, mk(1, 0, 1, 1)};
    vecs[3] = '{4'd8,  1'b0, 16'h0000, mk(1, 0, 8, 8)};
    vecs[4] = '{4'd15, 1'b0, 16'h0000, mk(1, 0, 15, 15)};
    vecs[5] = '{4'd0,  1'b1, 16'hAAAA, mk(0, 1, 15, 15)};
    vecs[6] = '{4'd0,  1'b1, 16'h0000, mk(0, 1, 15, 15)};
    vecs[7] = '{4'd0,  1'b1, 16'hFF00, mk(0, 1, 15, 15)};
    vecs[8] = '{4'd0,  1'b1, PAT,      mk(1, 0, 0, 0)};

    // Reset values, checked while reset is held and after release.
    @(negedge sclk);
    rstn = 1'b0;
    #1;
    check("rst_alignwd", {31'd0, alignwd}, 32'd0);
    check("rst_locked",  {31'd0, locked},  32'd0);
    check("rst_error",   {31'd0, error},   32'd0);
    check("rst_slip",    {28'd0, slip},    32'd0);
    check("rst_state",   {29'd0, dbg_state}, {29'd0, ST_IDLE});
    set_model(4'd0, 1'b0, 16'h0000);
    repeat (2) @(negedge sclk);
    rstn = 1'b1;
    repeat (10) @(negedge sclk);
    check("idle_no_start_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("idle_no_start_locked", {31'd0, locked}, 32'd0);
    check("idle_no_start_pulses", pulses, 32'd0);

    // Table-driven alignment runs.
    for (int i = 0; i < NV; i++) begin
      do_reset();
      set_model(vecs[i].off, vecs[i].fixed, vecs[i].word);
      exp_q.push_back(vecs[i].exp);
      pulse_start();
      wait_done($sformatf("vec%0d_done", i));
      got_w = {locked, error, slip, 5'(pulses)};
      check($sformatf("vec%0d_sb_size", i), exp_q.size(), 32'd1);
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        check($sformatf("vec%0d_result", i), {21'd0, got_w}, {21'd0, exp_w});
        repeat (20) @(negedge sclk);
        got_w = {locked, error, slip, 5'(pulses)};
        check($sformatf("vec%0d_hold", i), {21'd0, got_w}, {21'd0, exp_w});
        check($sformatf("vec%0d_alignwd_low", i), {31'd0, alignwd}, 32'd0);
        check($sformatf("vec%0d_state", i), {29'd0, dbg_state},
              {29'd0, (exp_w[W-1] ? ST_LOCK : ST_FAIL)});
      end
    end

    // Latency with Q already aligned: LOCKED rises after edge k+8.
    do_reset();
    set_model(4'd0, 1'b0, 16'h0000);
    pulse_start();
    check("lat_state_k", {29'd0, dbg_state}, {29'd0, ST_SETTLE});
    for (int j = 1; j <= 8; j++) begin
      @(negedge sclk);
      check($sformatf("lat_state_k+%0d", j), {29'd0, dbg_state},
            {29'd0, (j < 4) ? ST_SETTLE : ((j < 8) ? ST_CHECK : ST_LOCK)});
      check($sformatf("lat_locked_k+%0d", j), {31'd0, locked}, {31'd0, (j == 8)});
    end
    check("lat_pulses", pulses, 32'd0);

    // START on the edge that would complete the lock.
    do_reset();
    set_model(4'd0, 1'b0, 16'h0000);
    pulse_start();
    repeat (7) @(negedge sclk);
    check("race_pre_state", {29'd0, dbg_state}, {29'd0, ST_CHECK});
    pulse_start();
    check("race_locked", {31'd0, locked}, 32'd0);
    check("race_state", {29'd0, dbg_state}, {29'd0, ST_SETTLE});
    wait_done("race_relock_done");
    check("race_relock", {31'd0, locked}, 32'd1);

    // Reset while ALIGNWD is high truncates it at once.
    do_reset();
    set_model(4'd3, 1'b0, 16'h0000);
    pulse_start();
    wait_alignwd("rstp_first_pulse");
    @(negedge sclk);
    wait_alignwd("rstp_second_pulse");
    check("rstp_slip_before", {28'd0, slip}, 32'd1);
    #1;
    rstn = 1'b0;
    #1;
    check("rstp_alignwd", {31'd0, alignwd}, 32'd0);
    check("rstp_slip",    {28'd0, slip},    32'd0);
    check("rstp_locked",  {31'd0, locked},  32'd0);
    check("rstp_error",   {31'd0, error},   32'd0);
    @(negedge sclk);
    rstn = 1'b1;
    seen = pulses;
    repeat (12) @(negedge sclk);
    check("rstp_quiet_pulses", pulses, seen);
    check("rstp_quiet_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});

    // START during PULSE restarts and clears SLIP_CNT.
    do_reset();
    set_model(4'd3, 1'b0, 16'h0000);
    pulse_start();
    wait_alignwd("spulse_pulse");
    pulse_start();
    check("spulse_alignwd", {31'd0, alignwd}, 32'd0);
    check("spulse_slip", {28'd0, slip}, 32'd0);
    check("spulse_state", {29'd0, dbg_state}, {29'd0, ST_SETTLE});
    wait_done("spulse_done");
    check("spulse_final_slip", {28'd0, slip}, 32'd2);
    check("spulse_final_pulses", pulses, 32'd3);

    // ERROR cleared by START.
    do_reset();
    set_model(4'd0, 1'b1, 16'hAAAA);
    pulse_start();
    wait_done("err_done");
    check("err_set", {31'd0, error}, 32'd1);
    pulse_start();
    check("err_clear", {31'd0, error}, 32'd0);
    check("err_slip_clear", {28'd0, slip}, 32'd0);
    check("err_state", {29'd0, dbg_state}, {29'd0, ST_SETTLE});

    // Lock monitoring: 3 bad + 1 good keeps lock; 4 bad loses it (monitor only).
    do_reset();
    set_model(4'd0, 1'b0, 16'h0000);
    pulse_start();
    wait_done("mon_lock_done");
    check("mon_locked", {31'd0, locked}, 32'd1);
    fixed_mode = 1'b1;
    fixed_word = 16'h0000;
    repeat (3) @(negedge sclk);
    check("mon_3bad_locked", {31'd0, locked}, 32'd1);
    fixed_mode = 1'b0;
    @(negedge sclk);
    check("mon_good_locked", {31'd0, locked}, 32'd1);
    fixed_mode = 1'b1;
    repeat (3) @(negedge sclk);
    check("mon_3bad_again_locked", {31'd0, locked}, 32'd1);
    @(negedge sclk);
    fixed_mode = 1'b0;
`ifdef IDDRX8_ALIGN_MONITOR_EN
    check("mon_4bad_locked", {31'd0, locked}, 32'd0);
    check("mon_4bad_state", {29'd0, dbg_state}, {29'd0, ST_SETTLE});
    check("mon_4bad_slip", {28'd0, slip}, 32'd0);
    wait_done("mon_relock_done");
`else
    check("mon_4bad_locked", {31'd0, locked}, 32'd1);
    check("mon_4bad_state", {29'd0, dbg_state}, {29'd0, ST_LOCK});
    repeat (10) @(negedge sclk);
`endif
    check("mon_final_locked", {31'd0, locked}, 32'd1);
    check("mon_final_pulses", pulses, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iddrx8_word_align.md
IDDRX8_WORD_ALIGN -- requirements
Module: iddrx8_word_align

Interface
REQ-001 SHALL have parameter PATTERN, default 16'h00FF; the training word expected on Q after alignment (all 16 rotations distinct).
REQ-002 SHALL have parameter SETTLE_CYC, default 4; the SCLK cycles to wait after any slip/start before Q is compared (range 1..7).
REQ-003 SHALL have parameter MATCH_CNT, default 4; the consecutive matching words required to lock (range 1..7).
REQ-004 SHALL have port SCLK, input, 1; the single clock (gearbox slow clock); all logic rising-edge.
REQ-005 SHALL have port RSTN, input, 1; reset, asynchronous assert, active-low.
REQ-006 SHALL have port START, input, 1; a level sampled each edge that (re)starts alignment.
REQ-007 SHALL have port Q, input, 16; the deserialized word from the IDDRX8A outputs Q15..Q0 (Q[0]=Q0).
REQ-008 SHALL have port ALIGNWD, output, 1; the slip request to the gearbox, registered.
REQ-009 SHALL have port LOCKED, output, 1; word alignment achieved, registered.
REQ-010 SHALL have port ERROR, output, 1; all 16 alignments tried without lock, sticky, registered.
REQ-011 SHALL have port SLIP_CNT, output, 4; the slips issued since last start, registered.

Function
REQ-012 SHALL implement states IDLE, SETTLE, CHECK, PULSE, LOCK, FAIL.
REQ-013 IDLE: START=1 -> SETTLE; SLIP_CNT<=0; settle counter<=0.
REQ-014 SETTLE: count SCLK edges; after SETTLE_CYC edges -> CHECK with match counter cleared.
REQ-015 CHECK, Q==PATTERN: match counter +1; on reaching MATCH_CNT -> LOCK, LOCKED<=1.
REQ-016 CHECK, Q!=PATTERN with SLIP_CNT<15: -> PULSE, match counter<=0.
REQ-017 CHECK, Q!=PATTERN with SLIP_CNT==15: -> FAIL, ERROR<=1, no further ALIGNWD.
REQ-018 PULSE: ALIGNWD=1 for exactly one SCLK cycle; SLIP_CNT+1; -> SETTLE.
REQ-019 ALIGNWD SHALL never be high on two consecutive cycles; minimum gap is SETTLE_CYC+1 cycles.
REQ-020 LOCK: LOCKED held at 1 and SLIP_CNT frozen until START or reset (monitoring per REQ-029).
REQ-021 FAIL: ERROR held at 1 and LOCKED held at 0 until START or reset.
REQ-022 START=1 in any state, including PULSE, SHALL clear LOCKED, ERROR and SLIP_CNT and go to SETTLE on the same edge.
REQ-023 START SHALL take priority over a simultaneous lock, fail or pulse transition.
REQ-024 Latency: with Q already aligned, when START is sampled at edge k, LOCKED SHALL rise after edge k+SETTLE_CYC+MATCH_CNT (defaults: k+8).
REQ-025 SLIP_CNT SHALL never wrap; its maximum is 15.

Reset
REQ-026 RSTN=0 SHALL immediately force state IDLE, ALIGNWD=0, LOCKED=0, ERROR=0, SLIP_CNT=0, and all internal counters to 0.
REQ-027 Reset mid-PULSE SHALL truncate ALIGNWD asynchronously.
REQ-028 After RSTN deassertion the block SHALL stay in IDLE until START=1.

Configuration
REQ-029 Macro IDDRX8_ALIGN_MONITOR_EN defined: in LOCK, Q SHALL keep being compared each cycle; 4 consecutive mismatches -> LOCKED<=0, SLIP_CNT<=0, -> SETTLE (realign); any match clears the miss counter.
REQ-030 Macro undefined: no comparison in LOCK, no miss counter logic; LOCKED is held regardless of Q.

Verification
REQ-031 Aligned Q=16'h00FF, pulse START at edge 10 -> ALIGNWD never high, LOCKED=1 after edge 18, SLIP_CNT=0.
REQ-032 Q model rotates by 1 bit per ALIGNWD pulse, starting 3 slips off -> exactly 3 single-cycle ALIGNWD pulses, each separated by at least 5 cycles, then LOCKED=1 with SLIP_CNT=3.
REQ-033 Q held at 16'hAAAA -> 15 pulses, then ERROR=1, LOCKED=0, SLIP_CNT=15, ALIGNWD stays 0; START -> ERROR=0, SLIP_CNT=0.
REQ-034 RSTN=0 while ALIGNWD=1 -> all outputs 0 immediately; after release, no activity until START.
REQ-035 With IDDRX8_ALIGN_MONITOR_EN: locked, then Q=16'h0000 for 4 cycles -> LOCKED falls after the 4th edge; 3 bad words followed by 1 good word -> LOCKED stays 1. Without the macro, the same stimulus -> LOCKED stays 1.
REQ-036 START asserted on the edge that would complete MATCH_CNT -> LOCKED stays 0 and the state is SETTLE.
